// File: rtl/rv4028_bus_target.sv
// rv4028_bus_target: RV4028 16-bit bus target with word RAM, GPIO/IO registers and wait-state generator.
// Optional 32-bit cycle counter at IO 0x04/0x06 when RV4028_TGT_CYCLECNT_EN is defined.
module rv4028_bus_target #(
    parameter int MEM_WORDS_LOG2 = 8,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [1:0]  msk_n,
    input  logic        iorq_n,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic        wait_n,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out
);
    localparam int AW = MEM_WORDS_LOG2 > 7 ? MEM_WORDS_LOG2 : 7;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [AW:1] addr_q;
    logic [1:0] msk_q;
    logic wr_q, io_q;
    logic [15:0] wdata_q, rdata_q, gpio_q, sync1_q, sync2_q, io_rd;
    logic [15:0] mem [2**MEM_WORDS_LOG2];
    logic req, commit, we, re;
    logic [6:0] io_sel;
    logic [MEM_WORDS_LOG2-1:0] idx;
    logic unused_addr;
    assign unused_addr = ^{addr[31:AW+1], addr[0]};
    assign req = !mreq_n && (!rd_n || !wr_n);
    assign commit = state_q == ACCESS && !mreq_n;
    assign we = commit && wr_q;
    assign re = commit && !wr_q;
    assign io_sel = addr_q[7:1];
    assign idx = addr_q[MEM_WORDS_LOG2:1];
    assign wait_n = !(state_q == WAIT || state_q == ACCESS || (state_q == IDLE && req));
    assign data_oe = state_q == DONE && !wr_q;
    assign data_out = rdata_q;
    assign gpio_out = gpio_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                cnt_d = 4'(WAIT_CYCLES);
            end
            WAIT: begin
                state_d = mreq_n ? IDLE : (cnt_q == 4'd1 ? ACCESS : WAIT);
                cnt_d = cnt_q - 4'd1;
            end
            ACCESS: state_d = mreq_n ? IDLE : DONE;
            DONE: state_d = mreq_n ? IDLE : DONE;
        endcase
    end
`ifdef RV4028_TGT_CYCLECNT_EN
    logic [31:0] ccnt_q;
    logic [15:0] shadow_q;
    always_ff @(posedge clk) begin
        ccnt_q <= rst ? 32'h0 : ccnt_q + 32'h1;
        // shadow captures the upper half in the same cycle the low half is read
        shadow_q <= rst ? 16'h0 : (re && io_q && io_sel == 7'h02) ? ccnt_q[31:16] : shadow_q;
    end
    always_comb
        io_rd = io_sel == 7'h00 ? gpio_q :
                io_sel == 7'h01 ? sync2_q :
                io_sel == 7'h02 ? ccnt_q[15:0] :
                io_sel == 7'h03 ? shadow_q : 16'h0;
`else
    always_comb io_rd = io_sel == 7'h00 ? gpio_q : io_sel == 7'h01 ? sync2_q : 16'h0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= 4'h0;
            addr_q <= '0;
            msk_q <= 2'b11;
            wr_q <= 1'b0;
            io_q <= 1'b0;
            wdata_q <= 16'h0;
            rdata_q <= 16'h0;
            gpio_q <= 16'h0;
            sync1_q <= 16'h0;
            sync2_q <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            if (state_q == IDLE && req) begin
                addr_q <= addr[AW:1];
                msk_q <= msk_n;
                wr_q <= !wr_n;
                io_q <= !iorq_n;
                wdata_q <= data_in;
            end
            if (re) rdata_q <= io_q ? io_rd : mem[idx];
            if (we && io_q && io_sel == 7'h00) begin
                if (!msk_q[0]) gpio_q[7:0] <= wdata_q[7:0];
                if (!msk_q[1]) gpio_q[15:8] <= wdata_q[15:8];
            end
        end
    end
    // RAM contents are deliberately not reset; rst only blocks the commit
    always_ff @(posedge clk) begin
        if (!rst && we && !io_q) begin
            if (!msk_q[0]) mem[idx][7:0] <= wdata_q[7:0];
            if (!msk_q[1]) mem[idx][15:8] <= wdata_q[15:8];
        end
    end
endmodule

// File: doc/rv4028_bus_target.md
# rv4028_bus_target

Synchronous bus target on the RV4028 external 16-bit bus, directly downstream of the processor top level: it consumes the addr/rd_n/wr_n/msk_n/iorq_n/mreq_n strobes the core drives, and returns read data and wait_n. It provides a byte-maskable word RAM in memory space and a small GPIO/cycle-counter register file in IO space, with a parameterised wait-state generator. It runs in the core clock domain.

## Interface
- MEM_WORDS_LOG2, 8, RAM depth is 2^MEM_WORDS_LOG2 16-bit words.
- WAIT_CYCLES, 0, extra wait states inserted before every access (0..15).
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  byte address; bit 0 ignored (16-bit aligned).
- mreq_n  in  1  low while a bus transaction is in progress.
- rd_n  in  1  low = read request.
- wr_n  in  1  low = write request.
- msk_n  in  2  byte lane mask, low = lane active ([0]=data[7:0], [1]=data[15:8]).
- iorq_n  in  1  low = IO space, high = memory space.
- data_in  in  16  write data from master.
- data_out  out  16  read data to master.
- data_oe  out  1  high = target drives data bus.
- wait_n  out  1  low = access not ready.
- gpio_in  in  16  asynchronous inputs.
- gpio_out  out  16  GPIO output register.

## Operation
- Request = mreq_n low and (rd_n low or wr_n low), sampled on clk. rd_n and wr_n both low: treated as write.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE -> WAIT on request if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES), else -> ACCESS. Address, mask, direction, space and write data latched on this edge.
  - WAIT: counter decrements; -> ACCESS when counter reaches 1.
  - ACCESS: one cycle; write committed (active lanes only) or read data fetched into data_out register. -> DONE.
  - DONE: held until mreq_n sampled high, then -> IDLE.
  - mreq_n sampled high in WAIT or ACCESS: abort to IDLE; no write committed.
- wait_n = 0 in WAIT and ACCESS, and combinationally 0 in IDLE while a request is present; 1 otherwise.
- data_oe = 1 only in DONE of a read; data_out holds read value throughout DONE.
- Memory space (iorq_n high): word index = addr[MEM_WORDS_LOG2:1]; higher bits ignored (aliasing/wrap). Synchronous-read RAM, contents not reset.
- IO space (iorq_n low), decoded on addr[7:1], unmapped reads return 0x0000, unmapped writes ignored:
  - 0x00 gpio_out R/W, byte-maskable.
  - 0x02 gpio_in R, through 2-flop synchroniser.
  - 0x04 cycle counter [15:0] R; read also latches counter [31:16] into shadow.
  - 0x06 shadow [31:16] R.

## Timing
- Request first sampled in IDLE at cycle T0.
- wait_n low at T0 (combinational), stays low through T0+W+1 (W=WAIT_CYCLES).
- Write takes effect at end of T0+W+1; visible to any subsequent read.
- DONE at T0+W+2: wait_n=1, data_oe=1 and data_out valid for reads.
- Minimum transaction (W=0): 3 cycles request-to-release plus one IDLE cycle before next request is accepted.
- gpio_in to readable value: 2 cycles synchroniser latency.
- Reset values: state IDLE, wait_n=1, data_oe=0, data_out=0x0000, gpio_out=0x0000, cycle counter 0, shadow 0, synchroniser 0. Reset mid-transaction returns to IDLE on the next edge with no write committed.

## Configuration
- RV4028_TGT_CYCLECNT_EN defined: 32-bit free-running cycle counter increments every clk, wraps 0xFFFFFFFF->0; IO 0x04/0x06 map it as above.
- Not defined: counter and shadow not built; IO 0x04 and 0x06 read 0x0000 and are treated as unmapped.

## Test plan
- W=0: write 0xBEEF to mem 0x0010 (msk_n=00), read back -> wait_n low exactly T0..T0+1, data_oe high from T0+2, data_out=0xBEEF.
- Byte mask: mem 0x0010=0xBEEF, write 0x1234 with msk_n=10 -> read returns 0xBE34; msk_n=01 write 0x5600 -> 0x5634.
- W=3: read mem -> wait_n low for 5 consecutive cycles (T0..T0+4), data_oe at T0+5; mreq_n released at T0+2 -> FSM back to IDLE, data_oe never asserted.
- IO: write gpio_out 0xA5A5 -> gpio_out=0xA5A5 after ACCESS; gpio_in=0x00FF -> IO 0x02 reads 0x00FF; IO 0x3E reads 0x0000.
- Cycle counter (macro on): preload near 0x0000FFFF, read 0x04 then 0x06 -> high word consistent with low word across carry; macro off -> both read 0x0000.
- Reset asserted in ACCESS of a write to mem 0x0020 -> next cycle wait_n=1, data_oe=0, gpio_out=0, location 0x0020 unchanged.
